// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: 50%-duty output for any divisor >= 2,
// with glitch-free runtime divisor changes applied at period boundaries.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             divided_clk,
  output logic             tick,
  output logic             ack,
  output logic             err
);

  localparam logic [WIDTH-1:0] N_RST = WIDTH'(N_DEFAULT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic             run,    run_nxt;
  logic [WIDTH-1:0] cnt,    cnt_nxt;
  logic [WIDTH-1:0] n_act,  n_act_nxt;
  logic [WIDTH-1:0] n_pend, n_pend_nxt;
  logic             pv,     pv_nxt;
  logic             odd_q,  odd_nxt;
  logic             pos_q,  pos_nxt;
  logic             tick_nxt, ack_nxt, err_nxt;
  logic             neg_q;
  logic             bnd;
  logic [WIDTH-1:0] half, lim;

  // Next-state: period boundary handling, counting, divisor capture
  always_comb begin
    run_nxt    = run;
    cnt_nxt    = cnt + ONE;
    n_act_nxt  = n_act;
    n_pend_nxt = n_pend;
    pv_nxt     = pv;
    odd_nxt    = odd_q;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    bnd        = !run || (cnt == n_act - ONE);

    if (bnd) begin
      if (pv) begin
        n_act_nxt = n_pend;
        pv_nxt    = 1'b0;
        ack_nxt   = 1'b1;
      end
      odd_nxt = n_act_nxt[0];
      if (en) begin
        run_nxt = 1'b1;
        cnt_nxt = '0;
      end else begin
        run_nxt = 1'b0;
        cnt_nxt = n_act_nxt - ONE;
      end
    end

    // A load on a boundary edge lands in n_pend after the old one was consumed
    if (load) begin
      if (div_in < TWO) begin
        err_nxt = 1'b1;
      end else begin
        n_pend_nxt = div_in;
        pv_nxt     = 1'b1;
      end
    end

    half     = n_act_nxt >> 1;
    lim      = odd_nxt ? (half + ONE) : half;
    pos_nxt  = run_nxt && (cnt_nxt < lim);
    tick_nxt = run_nxt && (cnt_nxt == '0);
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run    <= 1'b0;
      cnt    <= N_RST - ONE;
      n_act  <= N_RST;
      n_pend <= N_RST;
      pv     <= 1'b0;
      odd_q  <= N_RST[0];
      pos_q  <= 1'b0;
      tick   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      run    <= run_nxt;
      cnt    <= cnt_nxt;
      n_act  <= n_act_nxt;
      n_pend <= n_pend_nxt;
      pv     <= pv_nxt;
      odd_q  <= odd_nxt;
      pos_q  <= pos_nxt;
      tick   <= tick_nxt;
      ack    <= ack_nxt;
      err    <= err_nxt;
    end
  end

  // Half-cycle delayed phase; ANDing it trims the high phase by 0.5 cycle for odd N
  always_ff @(negedge clk or posedge clr) begin
    if (clr) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  assign divided_clk = odd_q ? (pos_q & neg_q) : pos_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog: cycle-sampled outputs plus
// measured output period and high time.
`timescale 1ns/1ps
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       divided_clk, tick, ack, err;

  int n_chk = 0;
  int n_fail = 0;

  longint t_rise = -1;
  longint per = 0;
  longint high = 0;

  clk_div_prog #(.WIDTH(8), .N_DEFAULT(5)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .div_in(div_in),
    .divided_clk(divided_clk), .tick(tick), .ack(ack), .err(err)
  );

  always #10 clk = ~clk;

  // Rise-to-rise period and rise-to-fall high time of the divided clock
  always @(posedge divided_clk) begin
    if (t_rise >= 0) per = longint'($time) - t_rise;
    t_rise = longint'($time);
  end
  always @(negedge divided_clk) high = longint'($time) - t_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset and odd start (N=5); P0 = first posedge after release (t=50)
    #2 clr = 1'b1;
    en = 1'b1;
    cyc(2);
    check("rst_dclk", 32'(divided_clk), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    clr = 1'b0;
    cyc(1);                                   // P0
    check("t1_tick0", 32'(tick), 1);
    check("t1_dclk_pos", 32'(divided_clk), 0);
    @(negedge clk); #1;
    check("t1_dclk_neg", 32'(divided_clk), 1);
    for (int i = 1; i < 15; i++) begin
      cyc(1);
      check("t1_tick", 32'(tick), 32'(i % 5 == 0));
    end                                       // P14
    check("t1_per", 32'(per), 100);
    check("t1_high", 32'(high), 50);

    // 2: even divisor loaded mid-period
    cyc(2);                                   // P16, cnt=1
    load = 1'b1; div_in = 8'd4;
    cyc(1); load = 1'b0;                      // P17
    check("t2_ack_early", 32'(ack), 0);
    cyc(1);                                   // P18
    check("t2_old_high", 32'(high), 50);
    check("t2_ack_early", 32'(ack), 0);
    cyc(1);                                   // P19
    check("t2_ack_early", 32'(ack), 0);
    cyc(1);                                   // P20 boundary
    check("t2_ack", 32'(ack), 1);
    check("t2_tick", 32'(tick), 1);
    check("t2_dclk_posalign", 32'(divided_clk), 1);
    cyc(1);
    check("t2_ack_pulse", 32'(ack), 0);
    cyc(1);                                   // P22
    check("t2_dclk_low", 32'(divided_clk), 0);
    cyc(2);                                   // P24
    check("t2_dclk_high", 32'(divided_clk), 1);
    check("t2_per", 32'(per), 80);
    check("t2_high", 32'(high), 40);

    // 3: invalid load, then overwritten load
    load = 1'b1; div_in = 8'd1;
    cyc(1); load = 1'b0;                      // P25
    check("t3_err", 32'(err), 1);
    cyc(1);
    check("t3_err_pulse", 32'(err), 0);
    cyc(2);                                   // P28 boundary
    check("t3_no_ack", 32'(ack), 0);
    check("t3_tick", 32'(tick), 1);
    check("t3_per_kept", 32'(per), 80);
    load = 1'b1; div_in = 8'd7;
    cyc(1); div_in = 8'd3;                    // P29
    cyc(1); load = 1'b0;                      // P30
    cyc(1);                                   // P31
    check("t3_ack_early", 32'(ack), 0);
    cyc(1);                                   // P32 boundary
    check("t3_ack", 32'(ack), 1);
    check("t3_tick3", 32'(tick), 1);
    check("t3_dclk_odd", 32'(divided_clk), 0);
    for (int i = 33; i <= 38; i++) begin
      cyc(1);
      check("t3_single_ack", 32'(ack), 0);
    end
    cyc(1);                                   // P39
    check("t3_per", 32'(per), 60);
    check("t3_high", 32'(high), 30);

    // 4: enable gating with N=6
    load = 1'b1; div_in = 8'd6;
    cyc(1); load = 1'b0;                      // P40
    cyc(1);                                   // P41 boundary
    check("t4_ack", 32'(ack), 1);
    check("t4_tick", 32'(tick), 1);
    check("t4_dclk", 32'(divided_clk), 1);
    cyc(1); en = 1'b0;                        // P42
    cyc(2);                                   // P44
    check("t4_dclk_low", 32'(divided_clk), 0);
    cyc(1);
    check("t4_high", 32'(high), 60);
    cyc(1);                                   // P46
    for (int i = 47; i <= 52; i++) begin
      cyc(1);
      check("t4_stop_tick", 32'(tick), 0);
      check("t4_stop_dclk", 32'(divided_clk), 0);
    end
    en = 1'b1;
    cyc(1);                                   // P53 restart
    check("t4_restart_tick", 32'(tick), 1);
    check("t4_restart_dclk", 32'(divided_clk), 1);
    cyc(1);
    check("t4_tick_off", 32'(tick), 0);

    // 5: async reset mid-high with N=9, pending load discarded
    load = 1'b1; div_in = 8'd9;
    cyc(1); load = 1'b0;                      // P55
    cyc(4);                                   // P59 boundary
    check("t5_ack", 32'(ack), 1);
    check("t5_dclk_odd", 32'(divided_clk), 0);
    cyc(1);                                   // P60
    check("t5_dclk_high", 32'(divided_clk), 1);
    load = 1'b1; div_in = 8'd2;
    cyc(1); load = 1'b0;                      // P61
    check("t5_dclk_high2", 32'(divided_clk), 1);
    clr = 1'b1;
    #1;
    check("t5_clr_dclk", 32'(divided_clk), 0);
    check("t5_clr_tick", 32'(tick), 0);
    check("t5_clr_ack", 32'(ack), 0);
    check("t5_clr_err", 32'(err), 0);
    cyc(1); clr = 1'b0;                       // P62
    cyc(1);                                   // P63
    check("t5_restart_tick", 32'(tick), 1);
    check("t5_no_ack", 32'(ack), 0);
    check("t5_dclk", 32'(divided_clk), 0);
    for (int i = 64; i <= 68; i++) begin
      cyc(1);
      check("t5_tick", 32'(tick), 32'(i == 68));
    end
    cyc(1);                                   // P69
    check("t5_per_default", 32'(per), 100);
    check("t5_high_default", 32'(high), 50);

    // 6: extremes N=2 and N=255
    load = 1'b1; div_in = 8'd2;
    cyc(1); load = 1'b0;                      // P70
    cyc(3);                                   // P73 boundary
    check("t6_ack2", 32'(ack), 1);
    check("t6_dclk2", 32'(divided_clk), 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("t6_dclk2_seq", 32'(divided_clk), 32'(k % 2 == 0));
      check("t6_tick2_seq", 32'(tick), 32'(k % 2 == 0));
    end                                       // P77
    check("t6_per2", 32'(per), 40);
    check("t6_high2", 32'(high), 20);
    load = 1'b1; div_in = 8'd255;
    cyc(1); load = 1'b0;                      // P78
    cyc(1);                                   // P79 boundary
    check("t6_ack255", 32'(ack), 1);
    check("t6_tick255", 32'(tick), 1);
    cyc(254);                                 // P333
    check("t6_tick255_pre", 32'(tick), 0);
    cyc(1);                                   // P334
    check("t6_tick255_wrap", 32'(tick), 1);
    cyc(1);
    check("t6_per255", 32'(per), 5100);
    check("t6_high255", 32'(high), 2550);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable integer clock divider producing a 50%-duty divided clock for any divisor N ≥ 2, odd or even. It is the parametrised successor to the fixed odd-ratio divider: the width and reset divisor are parameters, and the divisor can be changed at runtime without glitches. Other blocks in the design use its output as a slow clock or strobe source, and `tick` gives them a period-aligned enable.

## Interface

Parameters:
- `WIDTH`, 8: width of the divisor and the internal counter.
- `N_DEFAULT`, 5: divisor loaded at reset. Must be ≥ 2 and < 2^WIDTH.

Ports:
- `clk` input, 1 bit: source clock. All logic runs on this one clock; both edges are used for odd N.
- `clr` input, 1 bit: asynchronous, active-high reset.
- `en` input, 1 bit: run enable, sampled at each period boundary.
- `load` input, 1 bit: single-cycle request to change the divisor to `div_in`.
- `div_in` input, WIDTH bits: requested divisor, captured when `load`=1.
- `divided_clk` output, 1 bit: divided clock.
- `tick` output, 1 bit: high for the first source cycle of each output period.
- `ack` output, 1 bit: one-cycle pulse in the first cycle of the first period that uses a newly loaded divisor.
- `err` output, 1 bit: one-cycle pulse, the cycle after a `load` with `div_in` < 2.

## Operation

Registers:
- `n_act`: active divisor.
- `n_pend`: pending divisor, with valid flag `pv`.
- `cnt`: period counter, WIDTH bits.
- `pos_q`: posedge phase flop.
- `neg_q`: negedge copy of `pos_q`.
- `H`: defined as `n_act`>>1.

States (encoded by `run` and `cnt`):
- IDLE: `run`=0, `cnt`=`n_act`−1, `pos_q`=0.
- RUN: `run`=1, `cnt` counts 0..`n_act`−1 and wraps.

Period boundary:
- A posedge where `run`=0, or where `run`=1 and `cnt`=`n_act`−1.
- At each boundary, if `pv`=1: `n_act`←`n_pend`, `pv`←0, and `ack` is set high for the next cycle.
- At each boundary, if `en`=1: `cnt`←0 and `run`←1. Otherwise `run`←0 (go to IDLE).
- Within a period, `en` changes have no effect until the next boundary.

Counting in RUN (not at a boundary): `cnt`←`cnt`+1.

`pos_q` is registered from the next value of `cnt`:
- Even N: high for `cnt` in [0, H−1].
- Odd N: high for `cnt` in [0, H].
- IDLE: 0.

Output:
- `neg_q` samples `pos_q` on the negedge.
- Even N: `divided_clk` = `pos_q`. High for H cycles, low for H cycles.
- Odd N: `divided_clk` = `pos_q` & `neg_q`. High for H+0.5 cycles, low for H+0.5 cycles, giving exact 50% duty.
- The odd/even select comes from `n_act[0]` and is registered so it only changes at a boundary.

`tick`: registered, equal to (RUN and `cnt`=0).

`load` handling:
- `div_in` ≥ 2: `n_pend`←`div_in`, `pv`←1. A second `load` before the boundary overwrites `n_pend`; only one `ack` is issued.
- `div_in` < 2: ignored, `err` pulses, and any existing pending value is kept.
- `load` on the same edge as a boundary: captured, but applied at the following boundary.

## Timing

Reset (`clr`=1):
- Clears immediately, independent of `clk`: `divided_clk`=0, `tick`=0, `ack`=0, `err`=0.
- `n_act`=`N_DEFAULT`, `pv`=0, IDLE state.
- Reset in mid-period truncates the output with no further edges. Pending loads are discarded.

Start-up:
- First posedge after `clr` falls with `en`=1: enter RUN, `cnt`=0, `tick`=1.
- Even N: `divided_clk` rises at that posedge.
- Odd N: `divided_clk` rises at the following negedge.

Steady state:
- Output period is exactly `n_act` source cycles.
- Rising edges stay posedge-aligned (even N) or negedge-aligned (odd N).

Divisor change:
- Takes effect at the first boundary after capture.
- No output pulse is shorter than min(old, new) half-periods.

Stop (`en`=0 at a boundary):
- The output stays low from the end of the current period's high phase.
- `tick` stays 0 while stopped.

Latency:
- `load` to `ack`: ≤ `n_act`+1 cycles.
- `load` to `err`: 1 cycle.

## Test plan

1. **Reset and odd start.** 20 ns clock, `clr` pulse, `en`=1, N=5. Expect `divided_clk` period 100 ns, high 50 ns, first rise 10 ns after the first posedge, and `tick` every 5 cycles.
2. **Even divisor.** `load` `div_in`=4 mid-period. Expect `ack` at the next boundary; from then on period is 80 ns, high 40 ns, posedge-aligned, and the old period completes intact.
3. **Invalid and overwritten loads.** `load` `div_in`=1 → `err` the next cycle and divisor unchanged. Then `load` 7 followed by `load` 3 within one period → a single `ack` and the new period is 3 cycles (high 30 ns).
4. **Enable gating.** `en`=0 mid-period with N=6. Expect the current period to complete, then the output stays low and `tick` stays 0. Set `en`=1 → restart at the next posedge with `cnt`=0.
5. **Asynchronous reset mid-high.** Assert `clr` while `divided_clk`=1 with N=9. Expect the output to go to 0 within the same cycle, and N=`N_DEFAULT` after release.
6. **Extremes.** N=2: period 2 cycles, 50% duty. N=255 with `WIDTH`=8: period 255 cycles, high 127.5 cycles.
